// File: rtl/nlp_biu_if.sv
// ============================================================================
// nlp_biu_if : core / prefetch / memory signal bundle for the nlp_biu block
// Rev 1.0
// ============================================================================
`default_nettype none

interface nlp_biu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_wr;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              i_pf_en;
  logic              i_pf_flush;
  logic [ADDR_W-1:0] i_pf_pc;
  logic              o_if_valid;
  logic [DATA_W-1:0] o_if_data;
  logic [ADDR_W-1:0] o_if_addr;
  logic              i_if_pop;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic              o_mem_wr;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    input  i_pf_en, i_pf_flush, i_pf_pc, i_if_pop,
    input  i_mem_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_if_valid, o_if_data, o_if_addr,
    output o_mem_valid, o_mem_wr, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    output i_pf_en, i_pf_flush, i_pf_pc, i_if_pop,
    output i_mem_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_if_valid, o_if_data, o_if_addr,
    input  o_mem_valid, o_mem_wr, o_mem_addr, o_mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/nlp_biu.sv
// ============================================================================
// nlp_biu : single-port bus interface unit arbitrating core data accesses
//           against an instruction prefetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

module nlp_biu #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int PQ_DEPTH = 4
) (
  input  wire logic   i_clk,
  input  wire logic   i_rst,
  nlp_biu_if.slave    bus
);
  localparam int              PTR_W  = $clog2(PQ_DEPTH);
  localparam logic [PTR_W:0]  C_FULL = (PTR_W+1)'(PQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic              w_start_data, w_start_fetch;
  logic              w_mem_done, w_fetch_done, w_push, w_pop, w_nonempty;

  logic              r_mem_valid, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_pf_ptr;
  logic              r_discard;

  logic [DATA_W-1:0] r_q_data [PQ_DEPTH];
  logic [ADDR_W-1:0] r_q_addr [PQ_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;

  assign w_mem_done   = r_mem_valid && bus.i_mem_ready;
  assign w_fetch_done = w_mem_done && (r_state == S_FETCH);
  // A flush landing on the completing fetch cycle also drops that word.
  assign w_push       = w_fetch_done && !r_discard && !bus.i_pf_flush;
  assign w_nonempty   = (r_count != '0);
  assign w_pop        = bus.i_if_pop && w_nonempty && !bus.i_pf_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_start_data  = 1'b0;
    w_start_fetch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          w_next       = S_DATA;
          w_start_data = 1'b1;
        end else if (bus.i_pf_en && !bus.i_pf_flush && (r_count < C_FULL)) begin
          w_next        = S_FETCH;
          w_start_fetch = 1'b1;
        end
      end
      S_DATA, S_FETCH: begin
        if (w_mem_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_valid <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start_data) begin
      r_mem_valid <= 1'b1;
      r_mem_wr    <= bus.i_req_wr;
      r_mem_addr  <= bus.i_req_addr;
      r_mem_wdata <= bus.i_req_wdata;
    end else if (w_start_fetch) begin
      r_mem_valid <= 1'b1;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= r_pf_ptr;
      r_mem_wdata <= '0;
    end else if (w_mem_done) begin
      r_mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_mem_done && (r_state == S_DATA);
      r_rsp_rdata <= (w_mem_done && (r_state == S_DATA) && !r_mem_wr) ? bus.i_mem_rdata : '0;
    end
  end

  // Flushing mid-fetch marks the outstanding word as stale; memory still completes it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pf_ptr  <= '0;
      r_discard <= 1'b0;
    end else if (bus.i_pf_flush) begin
      r_pf_ptr  <= bus.i_pf_pc;
      r_discard <= (r_state == S_FETCH) && !w_mem_done;
    end else if (w_fetch_done) begin
      if (!r_discard) r_pf_ptr <= r_pf_ptr + ADDR_W'(1);
      r_discard <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.i_pf_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= bus.i_mem_rdata;
      r_q_addr[r_wr_ptr] <= r_mem_addr;
    end
  end

  assign bus.o_req_ready = (r_state == S_IDLE);
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rsp_rdata;
  assign bus.o_if_valid  = w_nonempty;
  assign bus.o_if_data   = w_nonempty ? r_q_data[r_rd_ptr] : '0;
  assign bus.o_if_addr   = w_nonempty ? r_q_addr[r_rd_ptr] : '0;
  assign bus.o_mem_valid = r_mem_valid;
  assign bus.o_mem_wr    = r_mem_wr;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
endmodule

`default_nettype wire

// File: doc/nlp_biu.md
NLP_BIU -- requirements
Module: nlp_biu

Interface
REQ-001 Parameter DATA_W, default 16, width of data paths and prefetch queue entries.
REQ-002 Parameter ADDR_W, default 16, width of every address.
REQ-003 Parameter PQ_DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_req_valid  in  1  core data request present.
REQ-007 o_req_ready  out  1  data request accepted this cycle when high with i_req_valid.
REQ-008 i_req_wr  in  1  1 = write, 0 = read.
REQ-009 i_req_addr  in  ADDR_W  data address.
REQ-010 i_req_wdata  in  DATA_W  write data.
REQ-011 o_rsp_valid  out  1  one-cycle pulse: data access complete.
REQ-012 o_rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-013 i_pf_en  in  1  prefetch enable.
REQ-014 i_pf_flush  in  1  discard queue and restart fetch at i_pf_pc.
REQ-015 i_pf_pc  in  ADDR_W  new fetch address, sampled with i_pf_flush.
REQ-016 o_if_valid  out  1  queue head valid.
REQ-017 o_if_data  out  DATA_W  queue head instruction word.
REQ-018 o_if_addr  out  ADDR_W  address of queue head.
REQ-019 i_if_pop  in  1  consume queue head.
REQ-020 o_mem_valid  out  1  memory transaction pending (registered).
REQ-021 i_mem_ready  in  1  memory completes transaction this cycle.
REQ-022 o_mem_wr  out  1  transaction is a write.
REQ-023 o_mem_addr  out  ADDR_W  transaction address.
REQ-024 o_mem_wdata  out  DATA_W  transaction write data.
REQ-025 i_mem_rdata  in  DATA_W  read data, valid in cycle i_mem_ready is high.

Function
REQ-026 FSM states IDLE, DATA, FETCH; exactly one memory transaction outstanding at a time.
REQ-027 o_req_ready = 1 only in IDLE; in IDLE, i_req_valid moves to DATA (data has priority over prefetch).
REQ-028 In IDLE without i_req_valid: i_pf_en=1, i_pf_flush=0 and queue count < PQ_DEPTH move to FETCH at fetch pointer.
REQ-029 o_mem_valid/wr/addr/wdata registered on the entry edge; held stable until i_mem_ready; wait states unbounded.
REQ-030 DATA completion (o_mem_valid && i_mem_ready): return to IDLE; o_rsp_valid pulses next cycle with o_rsp_rdata = captured i_mem_rdata (read) or 0 (write).
REQ-031 Zero-wait-state read: accepted cycle N, o_mem_valid N+1, o_rsp_valid N+2.
REQ-032 FETCH completion: push {i_mem_rdata, address} into queue, fetch pointer += 1 modulo 2^ADDR_W, return to IDLE.
REQ-033 Queue is FIFO; o_if_valid = (count != 0); head outputs are 0 when empty.
REQ-034 Pop when i_if_pop && o_if_valid; pop on empty ignored; push and pop in same cycle leave count unchanged.
REQ-035 Fetch issued only at count < PQ_DEPTH, so a push never overflows.
REQ-036 i_pf_flush: queue empty and fetch pointer = i_pf_pc next cycle; flush beats simultaneous pop and push.
REQ-037 Flush while in FETCH: transaction runs to completion on the memory side; its data is discarded and the pointer is not incremented.
REQ-038 Flush never affects a DATA transaction or its response.
REQ-039 Deasserting i_pf_en stops new fetches; an in-flight fetch completes and is queued.

Reset
REQ-040 i_rst asynchronously forces IDLE, count 0, fetch pointer 0, discard flag 0; every output 0 except o_req_ready, which goes to 1 (state is IDLE).
REQ-041 Reset mid-transaction drops o_mem_valid immediately; the pending response is lost.

Verification
REQ-042 Read 0x0040, i_mem_ready tied 1, rdata 0xBEEF -> o_mem_valid one cycle, o_rsp_valid at N+2, o_rsp_rdata 0xBEEF.
REQ-043 Write 0x1234 to 0x0010, ready delayed 3 cycles -> addr/wdata stable 4 cycles, o_rsp_valid once, rdata 0.
REQ-044 Flush pc 0xFFFE, pf_en, no pops, memory returns the address -> queue fills 0xFFFE,0xFFFF,0x0000,0x0001 and then stops fetching.
REQ-045 Flush to 0x0100 during a 2-wait fetch of 0x0020 -> 0x0020 word discarded, first queued entry addr 0x0100.
REQ-046 Data request and free queue slot in same IDLE cycle -> data transaction issued first, fetch afterwards.
REQ-047 Assert i_rst while o_mem_valid=1 -> o_mem_valid=0 before the next edge, o_if_valid=0, o_req_ready=1.
